// File: rtl/adc_snapshot_capture.sv
// adc_snapshot_capture: circular I/Q capture that freezes a pre/post-trigger window
// and streams it out over a valid/ready port with a two-deep read pipeline.
module adc_snapshot_capture #(
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256
) (
  input  logic        clkin320,
  input  logic        rst_n,
  input  logic [15:0] i_in,
  input  logic [15:0] q_in,
  input  logic        in_valid,
  input  logic        arm,
  input  logic        trig,
  output logic        busy,
  output logic        armed,
  output logic        done,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        rd_last
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int POST_LEN = DEPTH - PRE_TRIG;

  localparam logic [AW-1:0] PRE_OFF   = AW'(PRE_TRIG);
  localparam logic [AW-1:0] AW_ONE    = AW'(1);
  localparam logic [CW-1:0] CW_ONE    = CW'(1);
  localparam logic [CW-1:0] FILL_LAST = CW'(PRE_TRIG - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(POST_LEN - 1);
  localparam logic [CW-1:0] WORDS     = CW'(DEPTH);
  localparam logic [CW-1:0] WORD_LAST = CW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, READ} state_t;

  state_t state, state_next;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   ram_q;
  logic [AW-1:0] wp;
  logic [AW-1:0] ra;
  logic [CW-1:0] cnt;
  logic          s1_valid;
  logic          s1_last;
  logic          we;
  logic          trig_hit;
  logic          issue;
  logic          issue_last;
  logic          out_free;
  logic          last_accept;
  logic          enter_read;

  // Next-state decode plus the write/read strobes that each state allows.
  always_comb begin
    state_next  = state;
    we          = 1'b0;
    trig_hit    = 1'b0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    last_accept = 1'b0;
    out_free    = !rd_valid || rd_ready;
    busy        = (state != IDLE);
    armed       = (state == ARMED);
    case (state)
      IDLE: begin
        if (arm) state_next = FILL;
      end
      FILL: begin
        we = in_valid;
        if (in_valid && cnt == FILL_LAST) state_next = ARMED;
      end
      ARMED: begin
        we       = in_valid;
        trig_hit = in_valid && trig;
        if (trig_hit) state_next = (POST_LEN == 1) ? READ : POST;
      end
      POST: begin
        we = in_valid;
        if (in_valid && cnt == POST_LAST) state_next = READ;
      end
      READ: begin
        issue       = (cnt < WORDS) && (!s1_valid || out_free);
        issue_last  = (cnt == WORD_LAST);
        last_accept = rd_valid && rd_ready && rd_last;
        if (last_accept) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    enter_read = (state != READ) && (state_next == READ);
  end

  // State register.
  always_ff @(posedge clkin320) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Write pointer, read pointer (latched as the window start on trigger) and the shared counter.
  always_ff @(posedge clkin320) begin
    if (!rst_n) begin
      wp  <= '0;
      ra  <= '0;
      cnt <= '0;
    end else begin
      if (we) wp <= wp + AW_ONE;
      if (trig_hit)   ra <= wp - PRE_OFF;
      else if (issue) ra <= ra + AW_ONE;
      if (enter_read)                cnt <= '0;
      else if (state == IDLE && arm) cnt <= '0;
      else if (trig_hit)             cnt <= CW_ONE;
      else if (we || issue)          cnt <= cnt + CW_ONE;
    end
  end

  // Sample RAM; write and read strobes come from disjoint states so they never collide.
  always_ff @(posedge clkin320) begin
    if (we)    mem[wp] <= {q_in, i_in};
    if (issue) ram_q   <= mem[ra];
  end

  // RAM output stage feeding the held output register, giving full rate with backpressure.
  always_ff @(posedge clkin320) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
      done     <= 1'b0;
    end else begin
      done <= last_accept;
      if (issue) begin
        s1_valid <= 1'b1;
        s1_last  <= issue_last;
      end else if (out_free) begin
        s1_valid <= 1'b0;
      end
      if (out_free) begin
        rd_valid <= s1_valid;
        rd_last  <= s1_valid && s1_last;
        if (s1_valid) rd_data <= ram_q;
      end
    end
  end

endmodule

// File: doc/adc_snapshot_capture.md
# adc_snapshot_capture

Triggered snapshot buffer on the 320 MHz read side of the ADC rate-change FIFO. It consumes the de-interleaved I/Q stream (one complex sample per `clkin320` cycle when valid) into a circular RAM. On a trigger it freezes a window of `DEPTH` samples, of which `PRE_TRIG` precede the trigger. It then streams the window out over a valid/ready interface for register or DMA readout.

## Interface
- `DEPTH`, 1024, capture window length in samples; power of two, ≥ 8
- `PRE_TRIG`, 256, samples kept before the trigger sample; 1 ≤ PRE_TRIG ≤ DEPTH-1
- `clkin320`  in  1  sole clock; all logic rises on it
- `rst_n`  in  1  synchronous, active-low reset
- `i_in`  in  16  I sample (two's complement)
- `q_in`  in  16  Q sample
- `in_valid`  in  1  `i_in`/`q_in` valid this cycle
- `arm`  in  1  single-cycle start request; honoured only in IDLE
- `trig`  in  1  trigger; qualified by `in_valid`, honoured only in ARMED
- `busy`  out  1  state ≠ IDLE
- `armed`  out  1  state == ARMED
- `done`  out  1  one-cycle pulse after the last readout word is accepted
- `rd_data`  out  32  {q, i}, Q in [31:16]
- `rd_valid`  out  1  `rd_data` valid
- `rd_ready`  in  1  consumer accepts the word when `rd_valid && rd_ready`
- `rd_last`  out  1  marks word DEPTH-1 of the window

## Operation
- Storage: DEPTH×32 single-clock RAM with write pointer `wp` (log2 DEPTH bits, wraps DEPTH-1→0) and a sample counter. The RAM is not reset.
- IDLE: no writes. `arm` moves to FILL and clears the counter. `wp` is not cleared.
- FILL: each `in_valid` writes mem[wp], then wp++ and cnt++. When cnt reaches PRE_TRIG, move to ARMED. `trig` is ignored in FILL, so the pre-trigger history is always complete.
- ARMED: continue circular writes. The trigger sample is the first `trig && in_valid` cycle. It is written at address wp (call it T). Latch start = (T − PRE_TRIG) mod DEPTH, set post count = 1, and move to POST. A `trig` without `in_valid` is ignored.
- POST: keep writing on `in_valid`. After DEPTH − PRE_TRIG samples counted from the trigger sample inclusive, stop writing and move to READ. Input is discarded from then on.
- READ: output mem[start], mem[start+1], … mem[start+DEPTH−1], with addresses wrapping mod DEPTH. Word k = PRE_TRIG is the trigger sample. `rd_last` is high with word DEPTH−1. When the last word is accepted, pulse `done` and return to IDLE.
- `arm` outside IDLE, and `trig` outside ARMED, have no effect.
- Reset mid-operation abandons the capture. A readout in progress is truncated; no `rd_last` and no `done` are issued.

## Timing
- Reset values: state IDLE, wp = 0, counters 0. `busy`, `armed`, `done`, `rd_valid` and `rd_last` are 0. `rd_data` is 0.
- `arm` at cycle N: `busy` = 1 at N+1. The first eligible write is the sample with `in_valid` at N+1.
- With `in_valid` held high, `armed` rises at N+1+PRE_TRIG.
- Trigger accepted at cycle M with `in_valid` continuous: the last write is at M + DEPTH − PRE_TRIG − 1.
- `rd_valid` rises no later than 2 cycles after READ entry. The RAM read latency is 1 cycle; use a prefetch/skid register.
- Readout throughput is 1 word per cycle while `rd_ready` = 1, with no bubbles.
- Once `rd_valid` is high, it and `rd_data`/`rd_last` stay stable until accepted.
- `done` is asserted in the cycle after the final handshake. `busy` is 0 in the same cycle `done` is 1.
- A write and a read never target the RAM in the same state, so no read-during-write hazard arises.

## Test plan
Bench parameters: DEPTH = 16, PRE_TRIG = 4. Stimulus ramp: i = n, q = 1000 + n, with `in_valid` continuous unless stated.
- Basic: reset; `arm` at sample n = 0; `trig` at n = 9; `rd_ready` = 1 → 16 words with i = 5…20. The word with i = 9 is index 4. `rd_last` is on i = 20, and `done` pulses once.
- Early trigger: `trig` held high from n = 0 → the trigger is taken at n = 4 (first ARMED sample). Output is i = 0…15.
- Wrap: a second capture after the basic run, `arm` at n = 30, `trig` at n = 50 → i = 46…61. The start address is nonzero and the readout wraps correctly.
- Gapped input/backpressure: `in_valid` toggled 1010…, `trig` applied on a valid cycle; `rd_ready` random 50% → data identical to the gapless case on the valid samples. `rd_data` stays stable while stalled, with no drops and no duplicates.
- Ignored controls: `arm` pulsed during POST and READ, and `trig` during FILL and READ → no change in state or output.
- Reset during READ after 7 words: `rd_valid` = 0 and `busy` = 0 next cycle; no `done`. A fresh capture afterwards is correct.
